multi_cycle_control_unit: RTL and testbench
===========================================

MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low; sampled on rising edge of clk.
REQ-004 opcode  input  7  IR[6:0] of the current instruction, valid from ID onward.
REQ-005 alu_bcond  input  1  branch compare result from ALU, valid in EX.
REQ-006 mem_ready  input  1  memory completion; access finishes in the cycle it is high.
REQ-007 halt_cond  input  1  high when x17 == 10, valid in ID.
REQ-008 pc_write  output  1  PC load enable.
REQ-009 pc_source  output  2  00 = PC+4, 01 = ALUOut.
REQ-010 i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut.
REQ-011 mem_read, mem_write, ir_write, reg_write  output  1 each  enables.
REQ-012 alu_src_a  output  1  0 = PC, 1 = reg A.
REQ-013 alu_src_b  output  2  00 = reg B, 01 = immediate.
REQ-014 alu_op  output  2  00 = add, 01 = branch compare, 10 = funct-decoded.
REQ-015 mem_to_reg  output  2  00 = ALUOut, 01 = MDR, 10 = PC+4.
REQ-016 is_halted  output  1  high while in HALT.
REQ-017 inst_retired  output  1  one-cycle pulse when an instruction completes.

Function
REQ-018 Six states SHALL exist: IF, ID, EX, MEM, WB, HALT. All outputs not listed for a state SHALL be 0.
REQ-019 IF SHALL assert mem_read and i_or_d = 0. It SHALL stay in IF while mem_ready = 0, and on mem_ready = 1 SHALL assert ir_write and move to ID.
REQ-020 ID SHALL drive alu_src_a = 0, alu_src_b = 01 and alu_op = 00 (ALUOut = PC+imm). Next state by opcode:
  - R, I-arith, LOAD, STORE, BRANCH, JALR -> EX
  - JAL -> WB
  - ECALL with halt_cond = 1 -> HALT
  - ECALL with halt_cond = 0, or any unknown opcode -> IF, with pc_write = 1, pc_source = 00 and inst_retired = 1
REQ-021 EX for R-type SHALL drive alu_src_a = 1, alu_src_b = 00, alu_op = 10; I-arith is identical except alu_src_b = 01. Both SHALL move to WB.
REQ-022 EX for LOAD, STORE and JALR SHALL drive alu_src_a = 1, alu_src_b = 01, alu_op = 00. LOAD and STORE SHALL move to MEM; JALR SHALL move to WB.
REQ-023 EX for BRANCH SHALL drive alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write = 1 and inst_retired = 1, with pc_source = 01 when alu_bcond = 1 and 00 otherwise (combinational on alu_bcond). It SHALL then move to IF.
REQ-024 MEM SHALL assert i_or_d = 1 plus mem_read (LOAD) or mem_write (STORE), held until mem_ready = 1.
  - LOAD on mem_ready -> WB.
  - STORE on mem_ready -> IF, with pc_write = 1, pc_source = 00 and inst_retired = 1 in that same cycle.
REQ-025 WB SHALL assert reg_write, pc_write and inst_retired, then move to IF.
  - mem_to_reg: 00 for R / I-arith, 01 for LOAD, 10 for JAL / JALR.
  - pc_source: 00 for R / I-arith / LOAD, 01 for JAL / JALR.
REQ-026 HALT SHALL be absorbing: is_halted = 1, all other outputs 0, exit only via reset.
REQ-027 Latency with mem_ready tied high SHALL be:
  - 4 cycles: R, I-arith, JALR, STORE
  - 5 cycles: LOAD
  - 3 cycles: BRANCH, JAL
  - 2 cycles: unknown opcode, non-halting ECALL
  Each cycle mem_ready is low in IF or MEM adds one cycle.
REQ-028 pc_write and reg_write SHALL never be high outside the states listed above; at most one inst_retired pulse per instruction.

Reset
REQ-029 While reset = 0 at a rising edge, state SHALL become IF on that edge, from any state including HALT, MEM mid-access, or while a memory wait is in progress.
REQ-030 While reset is low, all outputs SHALL be forced to 0, including mem_read and is_halted.
REQ-031 The first cycle after reset deasserts SHALL be IF, with mem_read = 1.

Structure
REQ-032 The state encodings (IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4, HALT = 5, 3 bits) and the pc_source / mem_to_reg / alu_op / alu_src_b code constants SHALL live in a shared header alongside opcodes.v; opcode values come from opcodes.v.
REQ-033 The design SHALL consist of one state register plus next-state logic.
REQ-034 The per-state output decode SHALL be one combinational sub-module, mc_ctrl_decode (inputs: state, opcode, alu_bcond, mem_ready; outputs: all control signals).

Verification
REQ-035 R-type add (0110011), mem_ready = 1 -> states IF,ID,EX,WB. Cycle 4 shows reg_write = 1, pc_write = 1, pc_source = 00, mem_to_reg = 00, inst_retired = 1.
REQ-036 LOAD (0000011), mem_ready low for 2 cycles in MEM -> mem_read and i_or_d = 1 held 3 cycles in MEM; WB at cycle 7 with mem_to_reg = 01.
REQ-037 BRANCH (1100011), alu_bcond = 1 -> cycle 3 shows pc_write = 1, pc_source = 01. Repeat with alu_bcond = 0 -> pc_source = 00. Both return to IF.
REQ-038 ECALL (1110011), halt_cond = 1 -> HALT at cycle 3; is_halted stays 1 for 20 cycles; no pc_write, no inst_retired. Then reset = 0 for 1 edge -> IF, is_halted = 0.
REQ-039 STORE (0100011), reset = 0 during MEM with mem_ready = 0 -> next cycle mem_write = 0 and state IF; no inst_retired.
REQ-040 Unknown opcode 0000000 -> ID asserts pc_write = 1, pc_source = 00, inst_retired = 1; back to IF, 2-cycle instruction.

Source files
------------

// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: state encodings,
// RV32I major opcodes, mux select codes and the control-word struct.
package multi_cycle_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  // Major opcodes (IR[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  // pc_source
  localparam logic [1:0] PC_SRC_PC4    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

  // mem_to_reg
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC4    = 2'b10;

  // alu_op
  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  // alu_src_b
  localparam logic [1:0] ALU_B_REG = 2'b00;
  localparam logic [1:0] ALU_B_IMM = 2'b01;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_I_ARITH,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_ECALL,
    CLS_UNKNOWN
  } op_class_e;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] mem_to_reg;
    logic       is_halted;
    logic       inst_retired;
  } ctrl_t;

  // Collapse the raw opcode into the instruction classes the FSM cares about.
  function automatic op_class_e op_class(input logic [6:0] op);
    op_class_e cls;
    case (op)
      OP_R:       cls = CLS_R;
      OP_I_ARITH: cls = CLS_I_ARITH;
      OP_LOAD:    cls = CLS_LOAD;
      OP_STORE:   cls = CLS_STORE;
      OP_BRANCH:  cls = CLS_BRANCH;
      OP_JAL:     cls = CLS_JAL;
      OP_JALR:    cls = CLS_JALR;
      OP_ECALL:   cls = CLS_ECALL;
      default:    cls = CLS_UNKNOWN;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Per-state control decode: purely combinational map from the current
// state and instruction class to the datapath control word.
module mc_ctrl_decode
  import multi_cycle_control_unit_pkg::*;
(
  input  state_e     state,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  op_class_e cls;

  assign cls = op_class(opcode);

  // Control word for the current state; anything not set here stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_IF: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b0;
        ctrl.ir_write = mem_ready;
      end
      ST_ID: begin
        // Speculative PC+imm into ALUOut for branches / JAL.
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALU_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
        // ECALL and unknown opcodes retire here; the top suppresses this
        // when the ECALL takes the halt path.
        if (cls == CLS_ECALL || cls == CLS_UNKNOWN) begin
          ctrl.pc_write     = 1'b1;
          ctrl.pc_source    = PC_SRC_PC4;
          ctrl.inst_retired = 1'b1;
        end
      end
      ST_EX: begin
        ctrl.alu_src_a = 1'b1;
        case (cls)
          CLS_R: begin
            ctrl.alu_src_b = ALU_B_REG;
            ctrl.alu_op    = ALU_OP_FUNCT;
          end
          CLS_I_ARITH: begin
            ctrl.alu_src_b = ALU_B_IMM;
            ctrl.alu_op    = ALU_OP_FUNCT;
          end
          CLS_LOAD, CLS_STORE, CLS_JALR: begin
            ctrl.alu_src_b = ALU_B_IMM;
            ctrl.alu_op    = ALU_OP_ADD;
          end
          CLS_BRANCH: begin
            ctrl.alu_src_b    = ALU_B_REG;
            ctrl.alu_op       = ALU_OP_BRANCH;
            ctrl.pc_write     = 1'b1;
            ctrl.inst_retired = 1'b1;
            ctrl.pc_source    = alu_bcond ? PC_SRC_ALUOUT : PC_SRC_PC4;
          end
          default: ctrl.alu_src_a = 1'b1;
        endcase
      end
      ST_MEM: begin
        ctrl.i_or_d = 1'b1;
        if (cls == CLS_LOAD) begin
          ctrl.mem_read = 1'b1;
        end else if (cls == CLS_STORE) begin
          ctrl.mem_write = 1'b1;
          // A store has nothing left to do once memory accepts it.
          if (mem_ready) begin
            ctrl.pc_write     = 1'b1;
            ctrl.pc_source    = PC_SRC_PC4;
            ctrl.inst_retired = 1'b1;
          end
        end
      end
      ST_WB: begin
        ctrl.reg_write    = 1'b1;
        ctrl.pc_write     = 1'b1;
        ctrl.inst_retired = 1'b1;
        case (cls)
          CLS_LOAD: begin
            ctrl.mem_to_reg = M2R_MDR;
            ctrl.pc_source  = PC_SRC_PC4;
          end
          CLS_JAL, CLS_JALR: begin
            ctrl.mem_to_reg = M2R_PC4;
            ctrl.pc_source  = PC_SRC_ALUOUT;
          end
          default: begin
            ctrl.mem_to_reg = M2R_ALUOUT;
            ctrl.pc_source  = PC_SRC_PC4;
          end
        endcase
      end
      ST_HALT: ctrl.is_halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control FSM: state register, next-state logic and the
// output stage wrapping the per-state decode.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IF    | fetch: read memory at PC, load IR when mem_ready
//   ID    | decode: ALUOut = PC+imm, pick path by opcode
//   EX    | execute / address calc / branch resolve
//   MEM   | data access at ALUOut, held until mem_ready
//   WB    | register write-back and PC update
//   HALT  | absorbing stop (ECALL with halt_cond), left only by reset
module multi_cycle_control_unit
  import multi_cycle_control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       mem_ready,
  input  logic       halt_cond,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] mem_to_reg,
  output logic       is_halted,
  output logic       inst_retired
);

  state_e    state_q;
  state_e    state_d;
  op_class_e cls;
  ctrl_t     dec_ctrl;
  ctrl_t     out_ctrl;

  assign cls = op_class(opcode);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IF: begin
        if (mem_ready) state_d = ST_ID;
      end
      ST_ID: begin
        case (cls)
          CLS_R, CLS_I_ARITH, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JALR:
            state_d = ST_EX;
          CLS_JAL:   state_d = ST_WB;
          CLS_ECALL: state_d = halt_cond ? ST_HALT : ST_IF;
          default:   state_d = ST_IF;
        endcase
      end
      ST_EX: begin
        case (cls)
          CLS_R, CLS_I_ARITH, CLS_JALR: state_d = ST_WB;
          CLS_LOAD, CLS_STORE:          state_d = ST_MEM;
          default:                      state_d = ST_IF;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d = (cls == CLS_LOAD) ? ST_WB : ST_IF;
        end
      end
      ST_WB:   state_d = ST_IF;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IF;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .alu_bcond (alu_bcond),
    .mem_ready (mem_ready),
    .ctrl      (dec_ctrl)
  );

  // Output stage: halting ECALL retires nothing, and reset blanks everything.
  always_comb begin
    out_ctrl = dec_ctrl;
    if (state_q == ST_ID && cls == CLS_ECALL && halt_cond) begin
      out_ctrl.pc_write     = 1'b0;
      out_ctrl.pc_source    = PC_SRC_PC4;
      out_ctrl.inst_retired = 1'b0;
    end
    if (!reset) begin
      out_ctrl = '0;
    end
  end

  assign pc_write     = out_ctrl.pc_write;
  assign pc_source    = out_ctrl.pc_source;
  assign i_or_d       = out_ctrl.i_or_d;
  assign mem_read     = out_ctrl.mem_read;
  assign mem_write    = out_ctrl.mem_write;
  assign ir_write     = out_ctrl.ir_write;
  assign reg_write    = out_ctrl.reg_write;
  assign alu_src_a    = out_ctrl.alu_src_a;
  assign alu_src_b    = out_ctrl.alu_src_b;
  assign alu_op       = out_ctrl.alu_op;
  assign mem_to_reg   = out_ctrl.mem_to_reg;
  assign is_halted    = out_ctrl.is_halted;
  assign inst_retired = out_ctrl.inst_retired;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed bench for multi_cycle_control_unit: walks each instruction class
// cycle by cycle and compares the full control word against hand-built values.
module tb_multi_cycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       alu_bcond;
  logic       mem_ready;
  logic       halt_cond;
  logic       pc_write;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] mem_to_reg;
  logic       is_halted;
  logic       inst_retired;

  int checks = 0;
  int failures = 0;

  multi_cycle_control_unit dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .alu_bcond    (alu_bcond),
    .mem_ready    (mem_ready),
    .halt_cond    (halt_cond),
    .pc_write     (pc_write),
    .pc_source    (pc_source),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .mem_to_reg   (mem_to_reg),
    .is_halted    (is_halted),
    .inst_retired (inst_retired)
  );

  always #5 clk = ~clk;

  // {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
  //  alu_src_a, alu_src_b, alu_op, mem_to_reg, is_halted, inst_retired}
  logic [16:0] obs;
  assign obs = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                reg_write, alu_src_a, alu_src_b, alu_op, mem_to_reg,
                is_halted, inst_retired};

  function automatic logic [16:0] mk(
    input logic pcw, input logic [1:0] pcs, input logic iod, input logic mr,
    input logic mw, input logic irw, input logic rw, input logic asa,
    input logic [1:0] asb, input logic [1:0] aop, input logic [1:0] m2r,
    input logic hlt, input logic ret);
    return {pcw, pcs, iod, mr, mw, irw, rw, asa, asb, aop, m2r, hlt, ret};
  endfunction

  localparam logic [16:0] E_ZERO      = 17'd0;
  localparam logic [16:0] E_IF_RDY    = mk(0,2'b00,0,1,0,1,0,0,2'b00,2'b00,2'b00,0,0);
  localparam logic [16:0] E_IF_WAIT   = mk(0,2'b00,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0);
  localparam logic [16:0] E_ID        = mk(0,2'b00,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
  localparam logic [16:0] E_ID_RET    = mk(1,2'b00,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,1);
  localparam logic [16:0] E_EX_R      = mk(0,2'b00,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
  localparam logic [16:0] E_EX_I      = mk(0,2'b00,0,0,0,0,0,1,2'b01,2'b10,2'b00,0,0);
  localparam logic [16:0] E_EX_ADDR   = mk(0,2'b00,0,0,0,0,0,1,2'b01,2'b00,2'b00,0,0);
  localparam logic [16:0] E_EX_BR_T   = mk(1,2'b01,0,0,0,0,0,1,2'b00,2'b01,2'b00,0,1);
  localparam logic [16:0] E_EX_BR_N   = mk(1,2'b00,0,0,0,0,0,1,2'b00,2'b01,2'b00,0,1);
  localparam logic [16:0] E_MEM_LD    = mk(0,2'b00,1,1,0,0,0,0,2'b00,2'b00,2'b00,0,0);
  localparam logic [16:0] E_MEM_ST    = mk(0,2'b00,1,0,1,0,0,0,2'b00,2'b00,2'b00,0,0);
  localparam logic [16:0] E_MEM_ST_OK = mk(1,2'b00,1,0,1,0,0,0,2'b00,2'b00,2'b00,0,1);
  localparam logic [16:0] E_WB_ALU    = mk(1,2'b00,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,1);
  localparam logic [16:0] E_WB_LD     = mk(1,2'b00,0,0,0,0,1,0,2'b00,2'b00,2'b01,0,1);
  localparam logic [16:0] E_WB_LINK   = mk(1,2'b01,0,0,0,0,1,0,2'b00,2'b00,2'b10,0,1);
  localparam logic [16:0] E_HALT      = mk(0,2'b00,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0);

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; opcode = 7'b0110011; mem_ready = 1'b1;
    alu_bcond = 1'b0; halt_cond = 1'b0;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      checks++;
      if (obs !== E_ZERO) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: got %b expected %b", i, obs, E_ZERO);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== E_IF_RDY) begin
      failures++;
      $display("FAIL reset_first_if: got %b expected %b", obs, E_IF_RDY);
    end
  endtask

  task automatic test_rtype();
    logic [16:0] e [4];
    e = '{E_IF_RDY, E_ID, E_EX_R, E_WB_ALU};
    opcode = 7'b0110011; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL rtype cycle %0d: got %b expected %b", i + 1, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_iarith();
    logic [16:0] e [4];
    e = '{E_IF_RDY, E_ID, E_EX_I, E_WB_ALU};
    opcode = 7'b0010011; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL iarith cycle %0d: got %b expected %b", i + 1, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_load_wait();
    logic [16:0] e [7];
    logic        r [7];
    e = '{E_IF_RDY, E_ID, E_EX_ADDR, E_MEM_LD, E_MEM_LD, E_MEM_LD, E_WB_LD};
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 7'b0000011;
    for (int i = 0; i < 7; i++) begin
      mem_ready = r[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL load_wait cycle %0d: got %b expected %b", i + 1, obs, e[i]);
      end
      next_cycle();
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_jal_fetch_wait();
    logic [16:0] e [4];
    logic        r [4];
    e = '{E_IF_WAIT, E_IF_RDY, E_ID, E_WB_LINK};
    r = '{1'b0, 1'b1, 1'b1, 1'b1};
    opcode = 7'b1101111;
    for (int i = 0; i < 4; i++) begin
      mem_ready = r[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL jal cycle %0d: got %b expected %b", i + 1, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_jalr();
    logic [16:0] e [4];
    e = '{E_IF_RDY, E_ID, E_EX_ADDR, E_WB_LINK};
    opcode = 7'b1100111; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL jalr cycle %0d: got %b expected %b", i + 1, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_branch(input logic taken);
    logic [16:0] e [3];
    e = '{E_IF_RDY, E_ID, taken ? E_EX_BR_T : E_EX_BR_N};
    opcode = 7'b1100011; mem_ready = 1'b1; alu_bcond = taken;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL branch_%0d cycle %0d: got %b expected %b", taken, i + 1, obs, e[i]);
      end
      if (i == 2) begin
        // pc_source must follow alu_bcond combinationally within EX.
        alu_bcond = ~taken;
        #1;
        checks++;
        if (obs !== (taken ? E_EX_BR_N : E_EX_BR_T)) begin
          failures++;
          $display("FAIL branch_bcond_comb: got %b expected %b",
                   obs, taken ? E_EX_BR_N : E_EX_BR_T);
        end
        alu_bcond = taken;
      end
      next_cycle();
    end
    alu_bcond = 1'b0;
  endtask

  task automatic test_store_wait();
    logic [16:0] e [5];
    logic        r [5];
    e = '{E_IF_RDY, E_ID, E_EX_ADDR, E_MEM_ST, E_MEM_ST_OK};
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    opcode = 7'b0100011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = r[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL store cycle %0d: got %b expected %b", i + 1, obs, e[i]);
      end
      next_cycle();
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_short(input logic [6:0] op, input string name);
    logic [16:0] e [2];
    e = '{E_IF_RDY, E_ID_RET};
    opcode = op; mem_ready = 1'b1; halt_cond = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, i + 1, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_ecall_halt();
    int bad = 0;
    opcode = 7'b1110011; mem_ready = 1'b1; halt_cond = 1'b1;
    #1;
    checks++;
    if (obs !== E_IF_RDY) begin
      failures++;
      $display("FAIL halt_if: got %b expected %b", obs, E_IF_RDY);
    end
    next_cycle();
    #1;
    checks++;
    if (obs !== E_ID) begin
      failures++;
      $display("FAIL halt_id_no_retire: got %b expected %b", obs, E_ID);
    end
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      halt_cond = i[1];
      #1;
      checks++;
      if (obs !== E_HALT) begin
        failures++;
        bad++;
        if (bad < 4) $display("FAIL halt_hold cycle %0d: got %b expected %b", i + 3, obs, E_HALT);
      end
      next_cycle();
    end
    halt_cond = 1'b0; mem_ready = 1'b1;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== E_ZERO) begin
      failures++;
      $display("FAIL halt_reset_low: got %b expected %b", obs, E_ZERO);
    end
    next_cycle();
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== E_IF_RDY) begin
      failures++;
      $display("FAIL halt_exit_if: got %b expected %b", obs, E_IF_RDY);
    end
  endtask

  task automatic test_store_reset();
    logic [16:0] e [4];
    logic        r [4];
    e = '{E_IF_RDY, E_ID, E_EX_ADDR, E_MEM_ST};
    r = '{1'b1, 1'b1, 1'b1, 1'b0};
    opcode = 7'b0100011;
    for (int i = 0; i < 4; i++) begin
      mem_ready = r[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL store_rst cycle %0d: got %b expected %b", i + 1, obs, e[i]);
      end
      if (i < 3) next_cycle();
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== E_ZERO) begin
      failures++;
      $display("FAIL store_rst_low: got %b expected %b", obs, E_ZERO);
    end
    next_cycle();
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (obs !== E_IF_WAIT) begin
      failures++;
      $display("FAIL store_rst_to_if: got %b expected %b", obs, E_IF_WAIT);
    end
    mem_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_iarith();
    test_load_wait();
    test_jal_fetch_wait();
    test_jalr();
    test_branch(1'b1);
    test_branch(1'b0);
    test_store_wait();
    test_short(7'b0000000, "unknown_op");
    test_short(7'b1110011, "ecall_nohalt");
    test_rtype();
    test_ecall_halt();
    test_store_reset();
    test_rtype();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
